// File: rtl/serial_rx_ctrl.sv
// serial_rx_ctrl: assembles N_WORD 16-bit words from UART bytes and checks the trailing CRC-16.
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module serial_rx_ctrl #(
  parameter logic [7:0] N_WORD = 8'h01,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        rx_done,
  input  logic [15:0] crc_16,
  output logic [15:0] word_out,
  output logic [7:0]  data_select,
  output logic        word_wr,
  output logic        crc_en,
  output logic        reset_crc,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy,
  output logic [2:0]  state
);
  localparam logic [2:0] IDLE = 3'd0, RX_HI = 3'd1, RX_LO = 3'd2, CRC_HI = 3'd3, CRC_LO = 3'd4;
  logic [2:0] state_q, state_d;
  logic rx_done_q;
  logic [7:0] hi_q, hi_d, crc_hi_q, crc_hi_d, idx_q, idx_d, data_select_q, data_select_d;
  logic [15:0] word_out_q, word_out_d;
  logic word_wr_q, word_wr_d, crc_en_q, crc_en_d, reset_crc_q, reset_crc_d;
  logic frame_ok_q, frame_ok_d, frame_err_q, frame_err_d, timeout_q, timeout_d;
  logic ev, last, wr, chk, tmo;
  assign ev = rx_done & ~rx_done_q;
  assign last = idx_q == N_WORD - 8'd1;
`ifdef RX_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == IDLE || ev) ? '0 : cnt_q + 16'd1;
  assign tmo = state_q != IDLE && !ev && cnt_q == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    cnt_q <= reset ? '0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif
  // edge register keeps sampling during reset so a level held across reset is not a new byte
  always_ff @(posedge clk) begin
    rx_done_q <= rx_done;
    if (reset) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      crc_hi_q      <= '0;
      idx_q         <= '0;
      word_out_q    <= '0;
      data_select_q <= '0;
      word_wr_q     <= 1'b0;
      crc_en_q      <= 1'b0;
      reset_crc_q   <= 1'b1;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      crc_hi_q      <= crc_hi_d;
      idx_q         <= idx_d;
      word_out_q    <= word_out_d;
      data_select_q <= data_select_d;
      word_wr_q     <= word_wr_d;
      crc_en_q      <= crc_en_d;
      reset_crc_q   <= reset_crc_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      timeout_q     <= timeout_d;
    end
  end
  always_comb begin
    state_d = tmo ? IDLE :
              !ev ? (state_q > CRC_LO ? IDLE : state_q) :
              (state_q == IDLE || state_q == RX_HI) ? RX_LO :
              state_q == RX_LO ? (last ? CRC_HI : RX_HI) :
              state_q == CRC_HI ? CRC_LO : IDLE;
  end
  always_comb begin
    wr            = ev && state_q == RX_LO;
    chk           = ev && state_q == CRC_LO;
    hi_d          = (ev && (state_q == IDLE || state_q == RX_HI)) ? byte_in : hi_q;
    crc_hi_d      = (ev && state_q == CRC_HI) ? byte_in : crc_hi_q;
    word_wr_d     = wr;
    word_out_d    = wr ? {hi_q, byte_in} : word_out_q;
    data_select_d = wr ? idx_q : data_select_q;
    idx_d         = state_d == IDLE ? '0 : wr ? (last ? '0 : idx_q + 8'd1) : idx_q;
    crc_en_d      = ev && (state_q == IDLE || state_q == RX_HI || state_q == RX_LO);
    frame_ok_d    = chk && {crc_hi_q, byte_in} == crc_16;
    frame_err_d   = (chk && {crc_hi_q, byte_in} != crc_16) || tmo;
    timeout_d     = tmo;
    reset_crc_d   = state_d == IDLE;
  end
  assign word_out    = word_out_q;
  assign data_select = data_select_q;
  assign word_wr     = word_wr_q;
  assign crc_en      = crc_en_q;
  assign reset_crc   = reset_crc_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign timeout     = timeout_q;
  assign busy        = state_q != IDLE;
  assign state       = state_q;
endmodule
